// File: rtl/ram_wait_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : ram_pkg                                                 |
// | Description : Shared types and constants for the wait-state RAM.      |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
package ram_pkg;

  // Width of the wait-state counter; wait values span 0..15
  localparam int WAIT_CNT_W = 4;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Latched access kind
  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram_wait_ctrl_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ram_array                                               |
// | Description : Word RAM, synchronous read port and byte-lane           |
// |               synchronous write port. Contents survive reset.         |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module ram_array #(
  parameter int DATA_W  = 16,
  parameter int DEPTH_W = 10
) (
  input  logic                  clk,
  input  logic                  wen,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DEPTH_W-1:0]    waddr,
  input  logic [DEPTH_W-1:0]    raddr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int WORDS = 1 << DEPTH_W;

  logic [DATA_W-1:0] mem_q [WORDS];
  logic [DATA_W-1:0] rdata_q;

  // Clear storage at time zero so never-written bytes read as zero
  initial begin
    for (int i = 0; i < WORDS; i++) begin
      mem_q[i] = '0;
    end
  end

  // Write port: only lanes with their enable set are updated
  always_ff @(posedge clk) begin
    if (wen) begin
      for (int l = 0; l < NB; l++) begin
        if (be[l]) begin
          mem_q[waddr][8*l +: 8] <= wdata[8*l +: 8];
        end
      end
    end
  end

  // Read port: registered every cycle from the current read address
  always_ff @(posedge clk) begin
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule : ram_array
`default_nettype wire

// File: rtl/ram_wait_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ram_wait_ctrl                                           |
// | Description : Single-port word RAM with re/we/ready handshake,        |
// |               programmable read/write wait states, byte enables and   |
// |               an out-of-range / conflicting-request error flag.       |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module ram_wait_ctrl
  import ram_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int DEPTH_W = 10,
  parameter int RD_WAIT = 0,
  parameter int WR_WAIT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                re,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic                busy,
  output logic                err
);

  localparam int NB = DATA_W / 8;
  localparam logic [WAIT_CNT_W-1:0] C_RD_WAIT = WAIT_CNT_W'(RD_WAIT);
  localparam logic [WAIT_CNT_W-1:0] C_WR_WAIT = WAIT_CNT_W'(WR_WAIT);
  localparam logic [WAIT_CNT_W-1:0] C_ONE     = WAIT_CNT_W'(1);

  // Registered state
  state_e                 state_q;
  logic [WAIT_CNT_W-1:0]  cnt_q;
  op_e                    op_q;
  logic [DEPTH_W-1:0]     addr_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [NB-1:0]          be_q;
  logic                   in_range_q;
  logic                   err_pend_q;
  logic                   run_q;      // low while in reset and for the release edge
  logic                   ready_q;
  logic                   busy_q;
  logic                   err_q;
  logic [DATA_W-1:0]      rdata_q;
  logic                   sel_arr_q;  // DONE cycle of an in-range read: present array word

  // Combinational helpers
  logic                   w_in_range;
  logic                   w_req;
  op_e                    w_op_in;
  logic [WAIT_CNT_W-1:0]  w_wait_in;
  logic                   w_err_in;
  logic                   w_fire_now;
  logic                   w_fire_wait;
  logic                   w_fire;
  op_e                    w_acc_op;
  logic [DEPTH_W-1:0]     w_acc_addr;
  logic [DATA_W-1:0]      w_acc_wdata;
  logic [NB-1:0]          w_acc_be;
  logic                   w_acc_in_range;
  logic                   w_acc_err;
  logic                   w_wen;
  logic [DATA_W-1:0]      w_arr_rdata;

  // Address is in range only when no bit above the implemented depth is set
  if (DEPTH_W < ADDR_W) begin : g_range
    assign w_in_range = (addr[ADDR_W-1:DEPTH_W] == '0);
  end else begin : g_full_range
    assign w_in_range = 1'b1;
  end

  // A simultaneous re and we is a write flagged as an error
  assign w_req     = run_q & (re | we);
  assign w_op_in   = we ? OP_WR : OP_RD;
  assign w_wait_in = we ? C_WR_WAIT : C_RD_WAIT;
  assign w_err_in  = (re & we) | ~w_in_range;

  // Array access happens on the edge that enters DONE: either the sampling
  // edge itself (zero wait) or the edge where the countdown expires.
  assign w_fire_now  = (state_q == IDLE) & w_req & (w_wait_in == '0);
  assign w_fire_wait = (state_q == WAIT) & (cnt_q == C_ONE);
  assign w_fire      = w_fire_now | w_fire_wait;

  // Zero-wait accesses use the request directly, others use the latched copy
  assign w_acc_op       = w_fire_now ? w_op_in             : op_q;
  assign w_acc_addr     = w_fire_now ? addr[DEPTH_W-1:0]   : addr_q;
  assign w_acc_wdata    = w_fire_now ? wdata               : wdata_q;
  assign w_acc_be       = w_fire_now ? be                  : be_q;
  assign w_acc_in_range = w_fire_now ? w_in_range          : in_range_q;
  assign w_acc_err      = w_fire_now ? w_err_in            : err_pend_q;

  // Out-of-range writes never reach the array, so there is no aliasing
  assign w_wen = w_fire & (w_acc_op == OP_WR) & w_acc_in_range;

  ram_array #(
    .DATA_W  (DATA_W),
    .DEPTH_W (DEPTH_W)
  ) u_array (
    .clk   (clk),
    .wen   (w_wen),
    .be    (w_acc_be),
    .waddr (w_acc_addr),
    .raddr (w_acc_addr),
    .wdata (w_acc_wdata),
    .rdata (w_arr_rdata)
  );

  // Controller: request capture, wait countdown, completion strobes and read-data hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= OP_RD;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      in_range_q <= 1'b0;
      err_pend_q <= 1'b0;
      run_q      <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      sel_arr_q  <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_req) begin
            op_q       <= w_op_in;
            addr_q     <= addr[DEPTH_W-1:0];
            wdata_q    <= wdata;
            be_q       <= be;
            in_range_q <= w_in_range;
            err_pend_q <= w_err_in;
            cnt_q      <= w_wait_in;
            busy_q     <= 1'b1;
            state_q    <= (w_wait_in == '0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - C_ONE;
          if (cnt_q == C_ONE) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          // Move the freshly read word into the hold register
          if (sel_arr_q) begin
            rdata_q   <= w_arr_rdata;
            sel_arr_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      if (w_fire) begin
        ready_q <= 1'b1;
        err_q   <= w_acc_err;
        if (w_acc_op == OP_RD) begin
          if (w_acc_in_range) begin
            sel_arr_q <= 1'b1;
          end else begin
            rdata_q <= '0;
          end
        end
      end
    end
  end

  // Both mux inputs are registers, so rdata has no path from the inputs
  assign rdata = sel_arr_q ? w_arr_rdata : rdata_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule : ram_wait_ctrl
`default_nettype wire

// File: tb/tb_ram_wait_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_ram_wait_ctrl                                        |
// | Description : Self-checking bench for ram_wait_ctrl. Three instances  |
// |               with different wait settings, each shadowed by a        |
// |               word-array reference model.                             |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module tb_ram_wait_ctrl;

  localparam int ND    = 3;
  localparam int WORDS = 1024;
  localparam int RDW [ND] = '{0, 3, 0};
  localparam int WRW [ND] = '{0, 2, 4};

  logic        clk = 1'b0;
  logic        rst     [ND];
  logic        re_s    [ND];
  logic        we_s    [ND];
  logic [15:0] addr_s  [ND];
  logic [15:0] wdata_s [ND];
  logic [1:0]  be_s    [ND];
  logic [15:0] rdata_s [ND];
  logic        ready_s [ND];
  logic        busy_s  [ND];
  logic        err_s   [ND];

  // Reference model: stored words and the last value a read returned
  logic [15:0] mdl     [ND][WORDS];
  logic [15:0] last_rd [ND];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    ram_wait_ctrl #(
      .DATA_W  (16),
      .ADDR_W  (16),
      .DEPTH_W (10),
      .RD_WAIT (RDW[gi]),
      .WR_WAIT (WRW[gi])
    ) u_dut (
      .clk   (clk),
      .rst   (rst[gi]),
      .re    (re_s[gi]),
      .we    (we_s[gi]),
      .addr  (addr_s[gi]),
      .wdata (wdata_s[gi]),
      .be    (be_s[gi]),
      .rdata (rdata_s[gi]),
      .ready (ready_s[gi]),
      .busy  (busy_s[gi]),
      .err   (err_s[gi])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One complete access on instance d, checked against the model
  task automatic access(input int d, input bit r, input bit w,
                        input logic [15:0] a, input logic [15:0] wd, input logic [1:0] b);
    int  wt;
    int  c;
    bit  inr;
    bit  exp_err;
    wt      = w ? WRW[d] : RDW[d];
    inr     = (a < 16'(WORDS));
    exp_err = (r && w) || !inr;
    if (w) begin
      if (inr) begin
        for (int l = 0; l < 2; l++) begin
          if (b[l]) mdl[d][a[9:0]][8*l +: 8] = wd[8*l +: 8];
        end
      end
    end else begin
      last_rd[d] = inr ? mdl[d][a[9:0]] : 16'h0000;
    end
    re_s[d] = r; we_s[d] = w; addr_s[d] = a; wdata_s[d] = wd; be_s[d] = b;
    @(posedge clk); #1;
    // Scramble the request lines: only the latched copy may matter now
    re_s[d] = 1'b0; we_s[d] = 1'b0;
    addr_s[d] = 16'($urandom); wdata_s[d] = 16'($urandom); be_s[d] = 2'($urandom);
    c = 0;
    while (!ready_s[d] && c < 40) begin
      chk($sformatf("busy_wait[%0d]", d), busy_s[d], 1);
      @(posedge clk); #1;
      c++;
    end
    chk($sformatf("latency[%0d]", d), c, wt);
    chk($sformatf("busy_ready[%0d]", d), busy_s[d], 1);
    chk($sformatf("err[%0d]", d), err_s[d], exp_err);
    chk($sformatf("rdata[%0d]@%0h", d, a), rdata_s[d], last_rd[d]);
    @(posedge clk); #1;
    chk($sformatf("ready_pulse[%0d]", d), ready_s[d], 0);
    chk($sformatf("busy_end[%0d]", d), busy_s[d], 0);
    chk($sformatf("rdata_hold[%0d]", d), rdata_s[d], last_rd[d]);
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      rst[d] = 1'b0; re_s[d] = 1'b0; we_s[d] = 1'b0;
      addr_s[d] = '0; wdata_s[d] = '0; be_s[d] = '0;
      last_rd[d] = '0;
      for (int i = 0; i < WORDS; i++) mdl[d][i] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst_ready[%0d]", d), ready_s[d], 0);
      chk($sformatf("rst_busy[%0d]", d),  busy_s[d],  0);
      chk($sformatf("rst_err[%0d]", d),   err_s[d],   0);
      chk($sformatf("rst_rdata[%0d]", d), rdata_s[d], 0);
      rst[d] = 1'b1;
    end
    @(posedge clk); @(posedge clk); #1;

    // Basic write/read with zero wait
    access(0, 0, 1, 16'h0000, 16'h1212, 2'b11);
    access(0, 1, 0, 16'h0000, 16'h0000, 2'b00);
    chk("basic_const", rdata_s[0], 16'h1212);

    // Wait states on instance 1
    access(1, 0, 1, 16'h0001, 16'h3434, 2'b11);
    access(1, 1, 0, 16'h0001, 16'h0000, 2'b00);
    chk("wait_const", rdata_s[1], 16'h3434);

    // Byte lanes
    access(0, 0, 1, 16'h0002, 16'h5656, 2'b11);
    access(0, 0, 1, 16'h0002, 16'hAB00, 2'b10);
    access(0, 1, 0, 16'h0002, 16'h0000, 2'b00);
    chk("lane_const", rdata_s[0], 16'hAB56);
    access(0, 0, 1, 16'h0002, 16'hFFFF, 2'b00);
    access(0, 1, 0, 16'h0002, 16'h0000, 2'b00);

    // Out of range, no aliasing onto 03CD
    access(0, 0, 1, 16'h03CD, 16'h2468, 2'b11);
    access(0, 0, 1, 16'hABCD, 16'h5656, 2'b11);
    access(0, 1, 0, 16'hABCD, 16'h0000, 2'b00);
    access(0, 1, 0, 16'h03CD, 16'h0000, 2'b00);
    chk("alias_const", rdata_s[0], 16'h2468);

    // re and we together
    access(0, 1, 1, 16'h0003, 16'h7777, 2'b11);
    access(0, 1, 0, 16'h0003, 16'h0000, 2'b00);
    access(1, 1, 1, 16'h0003, 16'h7777, 2'b11);
    access(1, 1, 0, 16'h0003, 16'h0000, 2'b00);

    // Reset in the middle of a write on instance 2
    access(2, 0, 1, 16'h0004, 16'h4444, 2'b11);
    access(2, 1, 0, 16'h0004, 16'h0000, 2'b00);
    re_s[2] = 1'b0; we_s[2] = 1'b1; addr_s[2] = 16'h0004; wdata_s[2] = 16'h9999; be_s[2] = 2'b11;
    @(posedge clk); #1;
    we_s[2] = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst[2] = 1'b0;
    #1;
    chk("abort_ready", ready_s[2], 0);
    chk("abort_busy",  busy_s[2],  0);
    chk("abort_err",   err_s[2],   0);
    chk("abort_rdata", rdata_s[2], 0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("abort_no_ready", ready_s[2], 0);
    end
    rst[2] = 1'b1;
    last_rd[2] = '0;
    @(posedge clk); @(posedge clk); #1;
    access(2, 1, 0, 16'h0004, 16'h0000, 2'b00);
    chk("abort_kept", rdata_s[2], 16'h4444);

    // Randomised traffic on every instance
    for (int d = 0; d < ND; d++) begin
      for (int n = 0; n < 40; n++) begin
        int          op;
        logic [15:0] a;
        op = $urandom_range(0, 7);
        a  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
        access(d, (op < 4) || (op == 7), (op >= 4), a, 16'($urandom), 2'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_ram_wait_ctrl
`default_nettype wire
